output_scheduler: RTL and testbench
===================================

OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the width of the data word handed to the nibble serializer.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of WAIT cycles allowed before the serializer reports done.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: level request from requester 0 and requester 1.
REQ-006 The block SHALL have ports data0 and data1, input, N bits each: the word from each requester, stable while its req is high.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle completion pulse to each requester.
REQ-008 The block SHALL have port ser_start, output, 1 bit: start strobe to the serializer.
REQ-009 The block SHALL have port ser_data, output, N bits: the word to be serialized.
REQ-010 The block SHALL have port ser_done, input, 1 bit: done flag from the serializer.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-013 The block SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT and ACK, with all outputs Moore-decoded from registered state.
REQ-015 In IDLE with a req high, the FSM SHALL capture the winner's data into data_reg and its index into gnt_reg, then go to ISSUE on the next edge.
REQ-016 Arbitration SHALL be as follows: with a single req, that requester wins; with both req high, the requester other than last_gnt wins.
REQ-017 last_gnt SHALL update only in ACK, and its reset value SHALL be 1, so requester 0 wins the first tie.
REQ-018 ISSUE SHALL last exactly one cycle with ser_start=1, then go to WAIT; ser_start SHALL be 0 in every other state.
REQ-019 ser_data SHALL equal data_reg from ISSUE through ACK, and SHALL be 0 in IDLE.
REQ-020 WAIT SHALL clear a timer on entry and increment it each cycle that ser_done is 0.
REQ-021 In WAIT, ser_done=1 SHALL move the FSM to ACK.
REQ-022 In WAIT, if the timer reaches TIMEOUT with ser_done=0, the FSM SHALL set err and move to ACK.
REQ-023 ACK SHALL last one cycle: ack[gnt_reg]=1, the other ack 0, last_gnt<=gnt_reg, then the FSM goes to IDLE.
REQ-024 req SHALL be sampled only in IDLE; a requester drops req at the edge ending its ack cycle, and a req still high in IDLE counts as a new request.
REQ-025 Changes on req or data during ISSUE, WAIT or ACK SHALL be ignored; the captured word is unaffected.
REQ-026 ser_done seen outside WAIT SHALL be ignored.
REQ-027 err_clr SHALL clear err; if err_clr and a timeout coincide, set SHALL win.
REQ-028 The timer SHALL be wide enough to hold TIMEOUT and SHALL saturate; it SHALL never wrap.
REQ-029 Nominal latency with a serializer that asserts done 9 cycles after start SHALL be: req in cycle 0, ser_start in cycle 1, ser_done in cycle 10, ack in cycle 11, IDLE in cycle 12.

Reset
REQ-030 reset SHALL force, at the next edge, state=IDLE, data_reg=0, gnt_reg=0, last_gnt=1, timer=0, err=0.
REQ-031 During reset, ack0, ack1, ser_start, busy and err SHALL be 0 and ser_data SHALL be 0.
REQ-032 Reset SHALL override all other inputs, and reset mid-transfer SHALL abort it with no ack issued.

Verification
REQ-033 The bench SHALL cover single request: req0=1, data0=0xDEADBEEF, serializer model with done 9 cycles after start -> ser_start in cycle 1 with ser_data=0xDEADBEEF, ack0 in cycle 11, ack1 never, err=0.
REQ-034 The bench SHALL cover a tie: req0=req1=1 from reset -> requester 0 served first, then requester 1 with its data; two consecutive ties alternate 0,1,0,1.
REQ-035 The bench SHALL cover timeout: req1=1 with serializer done tied 0 -> ack1 16 WAIT cycles after entering WAIT, err=1 and held; err_clr pulse -> err=0.
REQ-036 The bench SHALL cover input corruption: change data0 to 0x0 during WAIT -> ser_data stays at the captured value through ACK.
REQ-037 The bench SHALL cover reset mid-transfer: reset asserted in WAIT -> next cycle IDLE, no ack, busy=0; a new req0 then follows the nominal cycle-0/1/11 timing.
REQ-038 The bench SHALL cover stray done: ser_done pulsed in IDLE -> no state change, no ack.

Source files
------------

// File: rtl/output_scheduler.sv
// output_scheduler: arbitrates two requesters onto one nibble serializer.
// A winning word is captured in IDLE, strobed to the serializer in ISSUE,
// held while WAIT watches for done (or a timeout), and acknowledged in ACK.
module output_scheduler #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic         ser_start,
  output logic [N-1:0] ser_data,
  input  logic         ser_done,
  output logic         busy,
  output logic         err,
  input  logic         err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  data_reg;
  logic          gnt_reg;
  logic          last_gnt;
  logic [TW-1:0] timer;
  logic          err_reg;
  logic          any_req;
  logic          win;
  logic          timeout_hit;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = ~last_gnt;
    end else if (req1) begin
      win = 1'b1;
    end
    timeout_hit = (state == WAIT) && !ser_done && (timer >= TIMER_LAST);
  end

  // Next-state decode; timeout and done both leave WAIT for ACK.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (ser_done || timeout_hit) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture in IDLE, timer in ISSUE/WAIT, fairness memory in ACK, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      gnt_reg  <= 1'b0;
      last_gnt <= 1'b1;
      timer    <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        data_reg <= win ? data1 : data0;
        gnt_reg  <= win;
      end
      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT && !ser_done && timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
      if (state == ACK) begin
        last_gnt <= gnt_reg;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    ser_start = 1'b0;
    ser_data  = '0;
    busy      = 1'b0;
    err       = err_reg;
    if (state != IDLE) begin
      busy     = 1'b1;
      ser_data = data_reg;
    end
    if (state == ISSUE) begin
      ser_start = 1'b1;
    end
    if (state == ACK) begin
      ack0 = ~gnt_reg;
      ack1 = gnt_reg;
    end
  end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed self-checking bench for output_scheduler with a simple serializer model.
module tb_output_scheduler;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         req0;
  logic         req1;
  logic [N-1:0] data0;
  logic [N-1:0] data1;
  logic         ack0;
  logic         ack1;
  logic         ser_start;
  logic [N-1:0] ser_data;
  logic         ser_done;
  logic         busy;
  logic         err;
  logic         err_clr;

  logic         ser_auto;
  logic         model_done;
  logic         manual_done;
  int           cnt;

  int errors;
  int checks;

  output_scheduler #(.N(N), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .ser_start (ser_start),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ser_done = model_done | manual_done;

  // Serializer model: raises done for one cycle, 9 cycles after it sees start.
  always @(posedge clk) begin
    if (reset) begin
      cnt        <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (ser_auto && ser_start) begin
        cnt <= 8;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) model_done <= 1'b1;
      end
    end
  end

  // Advance one cycle and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 of a request; runs until an ack, dropping the served req in its ack cycle.
  task automatic wait_ack(input int limit, output int cyc, output logic a0, output logic a1,
                          output logic [N-1:0] start_data, output int start_cyc);
    cyc = -1; start_cyc = -1; a0 = 1'b0; a1 = 1'b0; start_data = '0;
    for (int c = 1; c <= limit; c++) begin
      step();
      if (ser_start && start_cyc < 0) begin
        start_cyc  = c;
        start_data = ser_data;
      end
      if (ack0 || ack1) begin
        cyc = c; a0 = ack0; a1 = ack1;
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; manual_done = 1'b1; err_clr = 1'b0;
    data0 = 32'hFFFF_FFFF; data1 = 32'hAAAA_AAAA;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack: got %b want 00", {ack0, ack1}); end
    checks++; if (ser_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b want 0", ser_start); end
    checks++; if (ser_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", ser_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    req0 = 1'b0; req1 = 1'b0; manual_done = 1'b0; reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int cyc, sc; logic a0, a1; logic [N-1:0] sd;
    ser_auto = 1'b1;
    req0 = 1'b1; data0 = 32'hDEAD_BEEF;
    wait_ack(40, cyc, a0, a1, sd, sc);
    checks++; if (sc !== 1) begin errors++; $display("[TB] FAIL single_start_cycle: got %0d want 1", sc); end
    checks++; if (sd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_ser_data: got %h want deadbeef", sd); end
    checks++; if (cyc !== 11) begin errors++; $display("[TB] FAIL single_ack_cycle: got %0d want 11", cyc); end
    checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("[TB] FAIL single_ack_which: got %b want 10", {a0, a1}); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b want 0", err); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_c12: got busy=%b want 0", busy); end
  endtask

  task automatic test_tie();
    int cyc, sc; logic a0, a1; logic [N-1:0] sd;
    logic [N-1:0] dw0 [2];
    logic [N-1:0] dw1 [2];
    dw0[0] = 32'h1111_0000; dw1[0] = 32'h2222_0001;
    dw0[1] = 32'h3333_0002; dw1[1] = 32'h4444_0003;
    ser_auto = 1'b1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req0 = 1'b1; req1 = 1'b1; data0 = dw0[r]; data1 = dw1[r];
      wait_ack(40, cyc, a0, a1, sd, sc);
      checks++; if ({a0, a1, cyc} !== {2'b10, 32'd11}) begin errors++; $display("[TB] FAIL tie%0d_first: got ack=%b cyc=%0d want ack=10 cyc=11", r, {a0, a1}, cyc); end
      checks++; if (sd !== dw0[r]) begin errors++; $display("[TB] FAIL tie%0d_first_data: got %h want %h", r, sd, dw0[r]); end
      wait_ack(40, cyc, a0, a1, sd, sc);
      checks++; if ({a0, a1, cyc, sc} !== {2'b01, 32'd12, 32'd2}) begin errors++; $display("[TB] FAIL tie%0d_second: got ack=%b cyc=%0d start=%0d want ack=01 cyc=12 start=2", r, {a0, a1}, cyc, sc); end
      checks++; if (sd !== dw1[r]) begin errors++; $display("[TB] FAIL tie%0d_second_data: got %h want %h", r, sd, dw1[r]); end
      step();
    end
  endtask

  task automatic test_timeout();
    int cyc, sc; logic a0, a1; logic [N-1:0] sd;
    ser_auto = 1'b0;
    req1 = 1'b1; data1 = 32'h5A5A_A5A5;
    wait_ack(40, cyc, a0, a1, sd, sc);
    checks++; if ({a0, a1, cyc} !== {2'b01, 32'd18}) begin errors++; $display("[TB] FAIL timeout_ack: got ack=%b cyc=%0d want ack=01 cyc=18", {a0, a1}, cyc); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_set: got %b want 1", err); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_held: got %b want 1", err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_clr: got %b want 0", err); end
    // err_clr held across a second timeout: the set must win.
    err_clr = 1'b1;
    req1 = 1'b1; data1 = 32'h0F0F_0F0F;
    wait_ack(40, cyc, a0, a1, sd, sc);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set_wins: got %b want 1", err); end
    err_clr = 1'b0;
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set_wins_held: got %b want 1", err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_clr2: got %b want 0", err); end
  endtask

  task automatic test_corruption();
    ser_auto = 1'b1;
    req0 = 1'b1; data0 = 32'h1234_5678;
    step(); step();
    data0 = 32'h0;
    checks++; if (ser_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL corrupt_c2: got %h want 12345678", ser_data); end
    for (int c = 3; c <= 11; c++) begin
      step();
      checks++; if (ser_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL corrupt_c%0d: got %h want 12345678", c, ser_data); end
    end
    checks++; if (ack0 !== 1'b1) begin errors++; $display("[TB] FAIL corrupt_ack: got %b want 1", ack0); end
    req0 = 1'b0;
    step();
    checks++; if (ser_data !== 32'h0) begin errors++; $display("[TB] FAIL corrupt_idle_data: got %h want 0", ser_data); end
  endtask

  task automatic test_reset_mid();
    int cyc, sc; logic a0, a1; logic [N-1:0] sd;
    ser_auto = 1'b1;
    req0 = 1'b1; data0 = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    checks++; if ({busy, ack0, ack1} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_state: got busy/ack0/ack1=%b want 000", {busy, ack0, ack1}); end
    checks++; if (ser_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset_data: got %h want 0", ser_data); end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if ({busy, ack0, ack1} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_quiet%0d: got %b want 000", i, {busy, ack0, ack1}); end
    end
    req0 = 1'b1; data0 = 32'h0BAD_F00D;
    wait_ack(40, cyc, a0, a1, sd, sc);
    checks++; if ({a0, a1, cyc, sc} !== {2'b10, 32'd11, 32'd1}) begin errors++; $display("[TB] FAIL midreset_retry: got ack=%b cyc=%0d start=%0d want ack=10 cyc=11 start=1", {a0, a1}, cyc, sc); end
    checks++; if (sd !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL midreset_retry_data: got %h want 0badf00d", sd); end
    step();
  endtask

  task automatic test_stray_done();
    manual_done = 1'b1;
    step();
    manual_done = 1'b0;
    checks++; if ({busy, ack0, ack1, ser_start} !== 4'b0000) begin errors++; $display("[TB] FAIL stray_done: got busy/ack0/ack1/start=%b want 0000", {busy, ack0, ack1, ser_start}); end
    step();
    checks++; if ({busy, ack0, ack1} !== 3'b000) begin errors++; $display("[TB] FAIL stray_done_after: got %b want 000", {busy, ack0, ack1}); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    err_clr = 1'b0; manual_done = 1'b0; ser_auto = 1'b0;
    $display("[TB] starting output_scheduler bench");
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_corruption();
    test_reset_mid();
    test_stray_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
